// File: rtl/debounce_pkg.sv
// Shared types for the level debouncer.
//   state_t : 2-bit FSM encoding. Bit 1 of the encoding is the reported
//             level, so STABLE_HI/WAIT_LO read as 1 and STABLE_LO/WAIT_HI as 0.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

endpackage

// File: rtl/debouncer.sv
// Level debouncer. The output level changes only after STABLE_CYCLES
// consecutive samples of i_d that differ from the current level. A single
// matching sample during a wait discards all accumulated count.
//
// Ports:
//   i_clk   - sole clock, all state updates on its rising edge
//   i_rst_n - asynchronous active-low reset
//   i_d     - level input, already synchronized to i_clk upstream
//   o_level - debounced level (registered)
//   o_rise  - one-cycle pulse in the first cycle o_level reads 1
//   o_fall  - one-cycle pulse in the first cycle o_level reads 0
//
// Input synchronization is not done here; i_d must come from a
// synchronizer stage.
module debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  // Count value at which the next differing sample commits the toggle.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             rise_q;
  logic             fall_q;

  // Pulses are set on the same edge that commits the new level, so they
  // appear together with it and clear on the following edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        STABLE_LO: begin
          if (i_d) begin
            state_q <= WAIT_HI;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_HI: begin
          if (!i_d) begin
            state_q <= STABLE_LO;      // glitch: no partial credit
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        STABLE_HI: begin
          if (!i_d) begin
            state_q <= WAIT_LO;
            cnt_q   <= CNT_W'(1);
          end else begin
            cnt_q   <= '0;
          end
        end
        WAIT_LO: begin
          if (i_d) begin
            state_q <= STABLE_HI;
            cnt_q   <= '0;
          end else if (cnt_q == LAST) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= STABLE_LO;
          cnt_q   <= '0;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;
  assign o_fall  = fall_q;

endmodule

// File: tb/tb_debouncer.sv
module tb_debouncer;

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic i_d = 1'b0;
  logic lvl4, rise4, fall4;
  logic lvl2, rise2, fall2;

  int tests = 0;
  int fails = 0;

  // Reference: run length of consecutive samples differing from the level.
  logic m_lvl  [2];
  logic m_rise [2];
  logic m_fall [2];
  int   m_run  [2];
  int   m_n    [2];
  logic prev_rise4, prev_fall4;

  debouncer #(.STABLE_CYCLES(4)) u_d4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_d),
    .o_level(lvl4), .o_rise(rise4), .o_fall(fall4)
  );

  debouncer #(.STABLE_CYCLES(2)) u_d2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_d),
    .o_level(lvl2), .o_rise(rise2), .o_fall(fall2)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_lvl[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_run[k] = 0;
    end
    prev_rise4 = 1'b0;
    prev_fall4 = 1'b0;
  endtask

  // One clock edge: advance the model with the sampled i_d, then compare
  // both DUTs against it 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk);
    if (i_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_rise[k] = 1'b0;
        m_fall[k] = 1'b0;
        if (i_d != m_lvl[k]) begin
          m_run[k]++;
          if (m_run[k] == m_n[k]) begin
            m_lvl[k]  = i_d;
            m_rise[k] = i_d;
            m_fall[k] = ~i_d;
            m_run[k]  = 0;
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
    #1;
    chk("mdl_lvl4",  lvl4,  m_lvl[0]);
    chk("mdl_rise4", rise4, m_rise[0]);
    chk("mdl_fall4", fall4, m_fall[0]);
    chk("mdl_lvl2",  lvl2,  m_lvl[1]);
    chk("mdl_rise2", rise2, m_rise[1]);
    chk("mdl_fall2", fall2, m_fall[1]);
    chk("no_both4", rise4 & fall4, 1'b0);
    chk("no_both2", rise2 & fall2, 1'b0);
    if (prev_rise4) chk("rise4_one_cycle", rise4, 1'b0);
    if (prev_fall4) chk("fall4_one_cycle", fall4, 1'b0);
    tests++;
    assert (u_d4.cnt_q <= 2'd3) else begin
      fails++;
      $error("FAIL cnt4_bound observed=%0d expected<=3", u_d4.cnt_q);
    end
    prev_rise4 = rise4;
    prev_fall4 = fall4;
  endtask

  initial begin
    m_n[0] = 4;
    m_n[1] = 2;
    model_reset();

    // Reset state
    #1;
    chk("rst_lvl", lvl4, 1'b0);
    chk("rst_rise", rise4, 1'b0);
    chk("rst_fall", fall4, 1'b0);
    tick(); tick();
    i_rst_n = 1'b1;

    // Constant low input: no activity
    for (int i = 0; i < 5; i++) tick();
    chk("idle_lvl", lvl4, 1'b0);

    // 0->1 held: toggle on the 4th edge sampling 1
    i_d = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("rise_wait_lvl", lvl4, 1'b0); end
    tick();
    chk("rise_lvl", lvl4, 1'b1);
    chk("rise_pulse", rise4, 1'b1);
    chk("rise_nofall", fall4, 1'b0);
    tick();
    chk("rise_pulse_end", rise4, 1'b0);
    chk("rise_lvl_hold", lvl4, 1'b1);

    // 1->0 held: fall pulse 4 edges later, rise stays low
    i_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fall_wait_lvl", lvl4, 1'b1);
      chk("fall_wait_norise", rise4, 1'b0);
    end
    tick();
    chk("fall_lvl", lvl4, 1'b0);
    chk("fall_pulse", fall4, 1'b1);
    chk("fall_norise", rise4, 1'b0);
    tick();
    chk("fall_pulse_end", fall4, 1'b0);

    // Glitch: 1 x3, 0 x1, then 1 held -> toggle on edge 8
    i_d = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    i_d = 1'b0;
    tick();
    i_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_lvl", lvl4, 1'b0);
      chk("glitch_norise", rise4, 1'b0);
    end
    tick();
    chk("glitch_toggle_lvl", lvl4, 1'b1);
    chk("glitch_toggle_rise", rise4, 1'b1);
    tick();
    chk("glitch_single_rise", rise4, 1'b0);
    i_d = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("glitch_back_lo", lvl4, 1'b0);

    // Reset mid-wait after 2 edges of 1: immediate clear without a clock
    i_d = 1'b1;
    tick(); tick();
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_lvl", lvl4, 1'b0);
    chk("async_rst_rise", rise4, 1'b0);
    chk("async_rst_fall", fall4, 1'b0);
    tick(); tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk("post_rst_wait", lvl4, 1'b0); end
    tick();
    chk("post_rst_lvl", lvl4, 1'b1);
    chk("post_rst_rise", rise4, 1'b1);

    // Reset while the level is high must clear it asynchronously
    #2 i_rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_hi_lvl", lvl4, 1'b0);
    chk("async_rst_hi_rise", rise4, 1'b0);
    i_d = 1'b0;
    tick();
    i_rst_n = 1'b1;
    tick();

    // STABLE_CYCLES=2 with i_d toggling every edge: never toggles
    for (int i = 0; i < 100; i++) begin
      i_d = ~i_d;
      tick();
      chk("tog2_lvl", lvl2, 1'b0);
      chk("tog2_rise", rise2, 1'b0);
      chk("tog2_fall", fall2, 1'b0);
    end

    // Random run: flip with probability 1/4 so runs span the threshold
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) i_d = ~i_d;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
